// File: rtl/dmux_stream.sv
// rtl/dmux_stream.sv - registered 1-to-2 stream demultiplexer with one FIFO and one word counter per output
// Each output FIFO is an instance of dmux_stream_fifo; the top only decodes the destination.

module dmux_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB separates full from empty once the pointers have wrapped.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full;
    assign do_pop  = pop_ready_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o = !empty;
    assign full_o  = full;
    assign count_o = count_q;
endmodule

module dmux_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;

    // Ready looks only at the selected FIFO's full flag, so a same-cycle pop never frees a slot.
    assign in_ready = in_sel ? !full_b : !full_a;
    assign push_a   = in_valid && in_ready && !in_sel;
    assign push_b   = in_valid && in_ready &&  in_sel;

    dmux_stream_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_fifo_a (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push_a),
        .push_data_i(in_data),
        .pop_ready_i(a_ready),
        .data_o     (a_data),
        .valid_o    (a_valid),
        .full_o     (full_a),
        .count_o    (a_count)
    );

    dmux_stream_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_fifo_b (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push_b),
        .push_data_i(in_data),
        .pop_ready_i(b_ready),
        .data_o     (b_data),
        .valid_o    (b_valid),
        .full_o     (full_b),
        .count_o    (b_count)
    );
endmodule
